// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, the
// responder FSM state encoding, the stall LFSR seed and small helpers
// used by the top level and the SRAM wrapper.
package dmem_responder_pkg;

  // Core-wide bus widths reused by the data-memory interface.
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;

  // Number of byte lanes in a data word.
  localparam int DMEM_LANES = RISCV_WORD_WIDTH / 8;

  // Width of the wait counter: covers LATENCY up to 15 plus up to 3 stall
  // cycles, minus the two cycles spent in IDLE and on the RESP-entry edge.
  localparam int DMEM_CNT_W = 5;

  // Reset seed of the optional stall-injection LFSR.
  localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // One step of the 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] dmem_lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage : dmem_responder_pkg

// File: rtl/dmem_sram.sv
// Single-port DEPTH_WORDS x 32 data array with per-byte write enables and a
// registered synchronous read. A read and a write to the same word on the
// same edge return the old contents (read-before-write).
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic [DMEM_LANES-1:0]       i_we,
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [RISCV_WORD_WIDTH-1:0] i_wdata,
  output logic [RISCV_WORD_WIDTH-1:0] o_rdata
);

  logic [RISCV_WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [RISCV_WORD_WIDTH-1:0] r_rdata;

  // Byte-lane write into the array on an enabled access.
  // NOTE: the array has no reset branch; resetting a RAM would force it into
  // flops, and the contents are defined to survive reset anyway.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < DMEM_LANES; b++) begin
        if (i_we[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read of the pre-write word; holds its value between accesses.
  // NOTE: non-blocking assignment here samples r_mem before this edge's write
  // lands, which is exactly what gives read-before-write behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule : dmem_sram

// File: rtl/dmem_responder.sv
// Responder side of the core's data-memory interface. Accepts one
// valid/ready request at a time, waits LATENCY cycles, then commits any
// byte-lane writes and returns the pre-write word with a one-cycle ready.
// Dropping valid while waiting aborts the request without side effects.
//
// Optional build macro DMEM_RAND_STALL_EN: adds 0..3 pseudo-random stall
// cycles per request, drawn from an 8-bit LFSR that steps on each acceptance.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dmem_valid_i,
  output logic                        dmem_ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
  input  logic [DMEM_LANES-1:0]       dmem_we_i,
  output logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e           r_state;
  dmem_state_e           w_state_nxt;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic [DMEM_CNT_W-1:0] w_cnt_nxt;
  logic [DMEM_CNT_W-1:0] w_total_lat;
  logic                  r_ready;
  logic                  w_enter_resp;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused_addr;

  // Word index; byte offset and bits above the array alias away.
  assign w_idx         = dmem_addr_i[IDX_W+1:2];
  assign w_unused_addr = ^{dmem_addr_i[RISCV_ADDR_WIDTH-1:IDX_W+2], dmem_addr_i[1:0]};

`ifdef DMEM_RAND_STALL_EN
  logic [7:0] r_lfsr;

  // Stall LFSR steps once per accepted request, including ones later aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= DMEM_LFSR_SEED;
    end else if (r_state == IDLE && dmem_valid_i) begin
      r_lfsr <= dmem_lfsr_next(r_lfsr);
    end
  end

  // Total latency of the request being accepted: base plus sampled stall.
  assign w_total_lat = DMEM_CNT_W'(LATENCY) + {{(DMEM_CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
  // Total latency is fixed at the configured base value.
  assign w_total_lat = DMEM_CNT_W'(LATENCY);
`endif

  // Next-state and wait-counter logic.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (dmem_valid_i) begin
          if (w_total_lat == DMEM_CNT_W'(1)) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = w_total_lat - DMEM_CNT_W'(2);
          end
        end
      end
      WAIT: begin
        if (!dmem_valid_i) begin
          // Initiator withdrew the request: abandon it with no side effects.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - DMEM_CNT_W'(1);
        end
      end
      RESP: begin
        // Held request is complete; valid is not looked at here.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The array is touched only on the edge that enters RESP.
  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

  // FSM state, wait counter and registered ready pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_enter_resp;
    end
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_enter_resp),
    .i_we    (dmem_we_i),
    .i_idx   (w_idx),
    .i_wdata (dmem_wdata_i),
    .o_rdata (dmem_rdata_o)
  );

  assign dmem_ready_o = r_ready;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 1, 3 and 4
// share clock and reset; each request's ready latency and returned word are
// compared against hand-computed values. Builds with or without
// DMEM_RAND_STALL_EN; with it, a bench-side LFSR supplies the extra stall.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        valid [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic [7:0]  m_lfsr [3];

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[0]), .dmem_ready_o(ready[0]),
    .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_we_i(we[0]), .dmem_rdata_o(rdata[0]));

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[1]), .dmem_ready_o(ready[1]),
    .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_we_i(we[1]), .dmem_rdata_o(rdata[1]));

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid[2]), .dmem_ready_o(ready[2]),
    .dmem_addr_i(addr[2]), .dmem_wdata_i(wdata[2]), .dmem_we_i(we[2]), .dmem_rdata_o(rdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
  function automatic logic [7:0] ref_lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 3; k++) m_lfsr[k] = 8'hA5;
  endtask

  // Wait n cycles, confirming at each mid-cycle that no ready is asserted.
  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check(tag, {29'b0, ready[0], ready[1], ready[2]}, 32'h0);
    end
  endtask

  // Issue one request at a negedge and hold it until ready. base_lat counts
  // cycles from this negedge to the cycle ready is high (LATENCY normally,
  // LATENCY+1 when issued straight from the previous RESP cycle).
  task automatic txn(input int k, input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, input int base_lat,
                     input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int exp_lat;
    int cnt;
    exp_lat = base_lat;
`ifdef DMEM_RAND_STALL_EN
    exp_lat += int'(m_lfsr[k][1:0]);
    m_lfsr[k] = ref_lfsr_step(m_lfsr[k]);
`endif
    cnt      = 0;
    valid[k] = 1'b1;
    addr[k]  = a;
    we[k]    = w;
    wdata[k] = d;
    do begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end while (!ready[k] && cnt < 40);
    check({tag, "_lat"}, cnt, exp_lat);
    if (chk_rd) check({tag, "_rdata"}, rdata[k], exp_rd);
    valid[k] = 1'b0;
    we[k]    = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; we[k] = 4'h0;
    end
    reset_models();

    // Reset state, then quiet idle period.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", {31'b0, ready[k]}, 32'h0);
      check("rst_rdata", rdata[k], 32'h0);
    end
    rst_n = 1'b1;
    idle(10, "idle_after_rst");

    // LATENCY=1: full-word write then read back.
    txn(0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1, 1'b0, 32'h0, "l1_wr10");
    idle(1, "l1_gap");
    txn(0, 32'h0000_0010, 4'h0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, "l1_rd10");
    idle(1, "l1_gap");

    // Byte lanes; writes return the pre-write word.
    txn(0, 32'h0000_0020, 4'hF, 32'h1122_3344, 1, 1'b0, 32'h0, "l1_wr20");
    idle(1, "l1_gap");
    txn(0, 32'h0000_0020, 4'b0100, 32'h00AA_0000, 1, 1'b1, 32'h1122_3344, "l1_wr20_b2");
    idle(1, "l1_gap");
    txn(0, 32'h0000_0020, 4'h0, 32'h0, 1, 1'b1, 32'h11AA_3344, "l1_rd20_a");
    idle(1, "l1_gap");
    txn(0, 32'h0000_0020, 4'b0011, 32'h0000_5566, 1, 1'b1, 32'h11AA_3344, "l1_wr20_b10");
    idle(1, "l1_gap");
    txn(0, 32'h0000_0020, 4'h0, 32'h0, 1, 1'b1, 32'h11AA_5566, "l1_rd20_b");
    // Back-to-back at LATENCY=1: next accepted in the IDLE cycle after RESP.
    txn(0, 32'h0000_0010, 4'h0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, "l1_b2b_rd10");
    idle(1, "l1_gap");

    // LATENCY=3: single read then a back-to-back read.
    txn(1, 32'h0000_0100, 4'hF, 32'hA1A2_A3A4, 3, 1'b0, 32'h0, "l3_wr100");
    idle(1, "l3_gap");
    txn(1, 32'h0000_0104, 4'hF, 32'hB1B2_B3B4, 3, 1'b0, 32'h0, "l3_wr104");
    idle(1, "l3_gap");
    txn(1, 32'h0000_0100, 4'h0, 32'h0, 3, 1'b1, 32'hA1A2_A3A4, "l3_rd100");
    txn(1, 32'h0000_0104, 4'h0, 32'h0, 4, 1'b1, 32'hB1B2_B3B4, "l3_b2b_rd104");
    idle(1, "l3_gap");

    // LATENCY=4: abort during WAIT leaves the array untouched.
    txn(2, 32'h0000_0040, 4'hF, 32'h1234_5678, 4, 1'b0, 32'h0, "l4_wr40");
    idle(1, "l4_gap");
    valid[2] = 1'b1; addr[2] = 32'h0000_0040; we[2] = 4'hF; wdata[2] = 32'hCAFE_F00D;
`ifdef DMEM_RAND_STALL_EN
    m_lfsr[2] = ref_lfsr_step(m_lfsr[2]);
`endif
    @(posedge clk);
    @(negedge clk);
    check("l4_abort_wait_ready", {31'b0, ready[2]}, 32'h0);
    valid[2] = 1'b0; we[2] = 4'h0;
    idle(6, "l4_abort_no_ready");
    txn(2, 32'h0000_0040, 4'h0, 32'h0, 4, 1'b1, 32'h1234_5678, "l4_rd40_after_abort");
    idle(1, "l4_gap");

    // Aliasing: bit 14 lies above the 4096-word index and is ignored.
    txn(2, 32'h0000_4040, 4'hF, 32'h0BAD_F00D, 4, 1'b1, 32'h1234_5678, "l4_wr4040");
    idle(1, "l4_gap");
    txn(2, 32'h0000_0040, 4'h0, 32'h0, 4, 1'b1, 32'h0BAD_F00D, "l4_rd40_alias");
    idle(1, "l4_gap");

    // Reset during WAIT: no ready, rdata cleared, write never commits.
    txn(2, 32'h0000_0044, 4'hF, 32'h4444_4444, 4, 1'b0, 32'h0, "l4_wr44");
    idle(1, "l4_gap");
    valid[2] = 1'b1; addr[2] = 32'h0000_0044; we[2] = 4'hF; wdata[2] = 32'hDEAD_0044;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wait_ready", {31'b0, ready[2]}, 32'h0);
    check("rst_mid_wait_rdata", rdata[2], 32'h0);
    valid[2] = 1'b0; we[2] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_models();
    idle(2, "after_mid_rst");
    txn(2, 32'h0000_0044, 4'h0, 32'h0, 4, 1'b1, 32'h4444_4444, "l4_rd44_after_rst");
    idle(1, "l4_gap");
    txn(0, 32'h0000_0010, 4'h0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, "l1_rd10_after_rst");
    idle(1, "l1_gap");

    // Run of consecutive reads; with stall injection each one's latency
    // follows the reference LFSR sequence.
    for (int i = 0; i < 8; i++) begin
      txn(0, 32'h0000_0020, 4'h0, 32'h0, 1, 1'b1, 32'h11AA_5566, "l1_seq_rd20");
      idle(1, "l1_seq_gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_dmem_responder
